// File: rtl/helppll_loopfilter_if.sv
// ---------------------------------------------------------------------------
// helppll_loopfilter_if
//   Tuning-word channel from the helper-PLL loop filter to the DAC serial
//   driver. Plain valid/ready transfer: a word moves on an edge where both
//   dac_valid and dac_ready are high.
//
//   dac_word   : unsigned tuning word, held stable while dac_valid is high
//   dac_valid  : dac_word is valid
//   dac_ready  : DAC driver accepts the word
//
//   master : loop filter side (drives word/valid)
//   slave  : DAC driver side (drives ready)
// ---------------------------------------------------------------------------
interface helppll_loopfilter_if #(
   parameter int DACWIDTH = 16
);
   logic [DACWIDTH-1:0] dac_word;
   logic                dac_valid;
   logic                dac_ready;

   modport master (output dac_word, output dac_valid, input dac_ready);
   modport slave  (input dac_word, input dac_valid, output dac_ready);
endinterface

// File: rtl/helppll_loopfilter.sv
// ---------------------------------------------------------------------------
// helppll_loopfilter
//   Shift-gain PI loop filter for the helper PLL. Each accepted signed
//   frequency-difference sample is negated into an error term, accumulated
//   into a clamped integrator and combined with a proportional term. The
//   saturated unsigned result goes to the DAC driver over valid/ready.
//
//   clk          : clkref-domain clock
//   rst_n        : asynchronous active-low reset
//   freqdiff     : signed helper-minus-reference frequency error
//   stb_freqdiff : one-cycle strobe, freqdiff valid
//   enable       : loop enable; low clears integrator and lock state
//   hold         : freeze integrator, proportional path stays active
//   dac          : tuning-word channel (master side)
//   locked       : LOCK_CNT consecutive samples within +/-LOCK_TOL
//   sat          : integrator or output clamp occurred on last update
//   drop_cnt     : saturating count of strobes discarded while busy
//   dbinteg      : integrator debug tap
// ---------------------------------------------------------------------------
module helppll_loopfilter #(
   parameter int DWIDTH   = 32,
   parameter int DACWIDTH = 16,
   parameter int KP_SHIFT = 4,
   parameter int KI_SHIFT = 8,
   parameter int DAC_MID  = 32768,
   parameter int LOCK_TOL = 2,
   parameter int LOCK_CNT = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic signed [DWIDTH-1:0]          freqdiff,
   input  logic                              stb_freqdiff,
   input  logic                              enable,
   input  logic                              hold,
   helppll_loopfilter_if.master              dac,
   output logic                              locked,
   output logic                              sat,
   output logic [7:0]                        drop_cnt,
   output logic signed [DWIDTH+KI_SHIFT-1:0] dbinteg
);
   localparam int EW  = DWIDTH + 1;            // error width, holds -(-2^(DWIDTH-1)) exactly
   localparam int IW  = DWIDTH + KI_SHIFT;     // integrator width
   localparam int SW  = DWIDTH + KI_SHIFT + 2; // output sum width
   localparam int LCW = $clog2(LOCK_CNT + 1);

   localparam longint IMAX_L = (longint'(1) << (DACWIDTH - 1 + KI_SHIFT)) - 1;
   localparam longint DMAX_L = (longint'(1) << DACWIDTH) - 1;
   localparam logic signed [IW:0]    INTEG_MAX = (IW+1)'(IMAX_L);
   localparam logic signed [IW:0]    INTEG_MIN = (IW+1)'(-IMAX_L - 1);
   localparam logic signed [SW-1:0]  DAC_MAX   = SW'(DMAX_L);
   localparam logic signed [SW-1:0]  MID_S     = SW'(DAC_MID);
   localparam logic signed [EW-1:0]  TOL_S     = EW'(LOCK_TOL);
   localparam logic [LCW-1:0]        LCNT_MAX  = LCW'(LOCK_CNT);
   localparam logic [LCW-1:0]        LCNT_LAST = LCW'(LOCK_CNT - 1);

   typedef enum logic [1:0] {IDLE, INTEG, SUM, OUT} state_t;

   state_t                 state_reg;
   logic signed [EW-1:0]   e_reg;
   logic signed [IW-1:0]   integ_reg;
   logic [LCW-1:0]         lockcnt_reg;
   logic                   integ_clamp_reg;
   logic                   out_clamp_reg;
   logic [DACWIDTH-1:0]    sum_reg;

   logic signed [EW-1:0]   neg_fd;
   logic signed [IW:0]     integ_sum;
   logic signed [IW-1:0]   integ_next;
   logic                   integ_clamp_next;
   logic signed [IW-1:0]   integ_shift;
   logic signed [EW-1:0]   e_shift;
   logic signed [SW-1:0]   raw;
   logic [DACWIDTH-1:0]    sum_next;
   logic                   out_clamp_next;
   logic                   in_tol;

   // Widen before negating so the most-negative freqdiff negates exactly.
   assign neg_fd  = -$signed({freqdiff[DWIDTH-1], freqdiff});
   assign in_tol  = (e_reg <= TOL_S) && (e_reg >= -TOL_S);
   assign dbinteg = integ_reg;

   // Integrator update with one guard bit so the clamp sees true overflow.
   always_comb begin
      integ_sum        = $signed({integ_reg[IW-1], integ_reg}) +
                         $signed({{(IW+1-EW){e_reg[EW-1]}}, e_reg});
      integ_clamp_next = 1'b0;
      integ_next       = integ_sum[IW-1:0];
      if (integ_sum > INTEG_MAX) begin
         integ_next       = INTEG_MAX[IW-1:0];
         integ_clamp_next = 1'b1;
      end else if (integ_sum < INTEG_MIN) begin
         integ_next       = INTEG_MIN[IW-1:0];
         integ_clamp_next = 1'b1;
      end
   end

   // Output sum: mid-scale + integral + proportional, clamped to DAC range.
   always_comb begin
      integ_shift    = integ_reg >>> KI_SHIFT;
      e_shift        = e_reg >>> KP_SHIFT;
      raw            = MID_S +
                       $signed({{(SW-IW){integ_shift[IW-1]}}, integ_shift}) +
                       $signed({{(SW-EW){e_shift[EW-1]}}, e_shift});
      out_clamp_next = 1'b0;
      sum_next       = raw[DACWIDTH-1:0];
      if (raw[SW-1]) begin
         sum_next       = '0;
         out_clamp_next = 1'b1;
      end else if (raw > DAC_MAX) begin
         sum_next       = '1;
         out_clamp_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         e_reg           <= '0;
         integ_reg       <= '0;
         lockcnt_reg     <= '0;
         integ_clamp_reg <= 1'b0;
         out_clamp_reg   <= 1'b0;
         sum_reg         <= DACWIDTH'(DAC_MID);
         dac.dac_word    <= DACWIDTH'(DAC_MID);
         dac.dac_valid   <= 1'b0;
         locked          <= 1'b0;
         sat             <= 1'b0;
         drop_cnt        <= '0;
      end else begin
         // Strobes are only counted as drops while the loop is enabled.
         if (enable && stb_freqdiff && state_reg != IDLE && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;

         case (state_reg)
            IDLE: begin
               if (enable && stb_freqdiff) begin
                  e_reg     <= neg_fd;
                  state_reg <= INTEG;
               end
            end
            INTEG: begin
               if (!hold)
                  integ_reg <= integ_next;
               integ_clamp_reg <= !hold && integ_clamp_next;
               if (in_tol) begin
                  if (lockcnt_reg != LCNT_MAX)
                     lockcnt_reg <= lockcnt_reg + 1'b1;
                  if (lockcnt_reg >= LCNT_LAST)
                     locked <= 1'b1;
               end else begin
                  lockcnt_reg <= '0;
                  locked      <= 1'b0;
               end
               state_reg <= SUM;
            end
            SUM: begin
               sum_reg       <= sum_next;
               out_clamp_reg <= out_clamp_next;
               state_reg     <= OUT;
            end
            OUT: begin
               // First OUT cycle presents the word; later cycles wait for ready.
               if (!dac.dac_valid) begin
                  dac.dac_word  <= sum_reg;
                  dac.dac_valid <= 1'b1;
                  sat           <= integ_clamp_reg | out_clamp_reg;
               end else if (dac.dac_ready) begin
                  dac.dac_valid <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase

         // Disabling clears loop state but lets an in-flight word finish.
         if (!enable) begin
            integ_reg   <= '0;
            lockcnt_reg <= '0;
            locked      <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_helppll_loopfilter.sv
module tb_helppll_loopfilter;
   logic                clk;
   logic                rst_n;
   logic signed [31:0]  freqdiff;
   logic                stb_freqdiff;
   logic                enable;
   logic                hold;
   logic                locked;
   logic                sat;
   logic [7:0]          drop_cnt;
   logic signed [39:0]  dbinteg;

   helppll_loopfilter_if #(.DACWIDTH(16)) dac_if ();

   helppll_loopfilter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .freqdiff     (freqdiff),
      .stb_freqdiff (stb_freqdiff),
      .enable       (enable),
      .hold         (hold),
      .dac          (dac_if),
      .locked       (locked),
      .sat          (sat),
      .drop_cnt     (drop_cnt),
      .dbinteg      (dbinteg)
   );

   typedef struct {
      int word;
      bit sat;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one strobe and push the hand-computed expected output.
   // The strobe is sampled at posedge cyc+1; valid rises at cyc+4 and is
   // first seen by the monitor after that edge.
   task automatic send(input logic signed [31:0] fd, input int word, input bit s);
      exp_t e;
      @(negedge clk);
      freqdiff     = fd;
      stb_freqdiff = 1'b1;
      e.word = word;
      e.sat  = s;
      e.lat  = cyc + 4;
      sb.push_back(e);
      @(negedge clk);
      stb_freqdiff = 1'b0;
   endtask

   // Strobe with no expected output (dropped or cut off by reset).
   task automatic pulse(input logic signed [31:0] fd);
      @(negedge clk);
      freqdiff     = fd;
      stb_freqdiff = 1'b1;
      @(negedge clk);
      stb_freqdiff = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_loop();
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
   endtask

   // Monitor: compares each transfer against the scoreboard head.
   logic        prev_valid = 1'b0;
   logic        expect_low = 1'b0;
   logic [15:0] held_word  = '0;
   int          rise_cyc   = 0;

   always begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         prev_valid = 1'b0;
         expect_low = 1'b0;
      end else begin
         if (expect_low) begin
            chk("valid_pulse_end", dac_if.dac_valid, 0);
            expect_low = 1'b0;
         end
         if (dac_if.dac_valid && !prev_valid)
            rise_cyc = cyc;
         if (dac_if.dac_valid && prev_valid)
            chk("word_stable", dac_if.dac_word, held_word);
         held_word = dac_if.dac_word;
         if (dac_if.dac_valid && dac_if.dac_ready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_xfer: got word %0d expected none", dac_if.dac_word);
            end else begin
               exp_t e;
               e = sb.pop_front();
               $display("xfer word=%0d sat=%0b at cycle %0d", dac_if.dac_word, sat, cyc);
               chk("dac_word", dac_if.dac_word, e.word);
               chk("sat", sat, e.sat);
               chk("latency", rise_cyc, e.lat);
            end
            expect_low = 1'b1;
         end
         prev_valid = dac_if.dac_valid;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n            = 1'b0;
      freqdiff         = '0;
      stb_freqdiff     = 1'b0;
      enable           = 1'b0;
      hold             = 1'b0;
      dac_if.dac_ready = 1'b0;

      // Reset state
      idle(3);
      chk("rst_word", dac_if.dac_word, 32768);
      chk("rst_valid", dac_if.dac_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      chk("rst_locked", locked, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_sat", sat, 0);
      chk("rst_integ", dbinteg, 0);
      chk("rst_word2", dac_if.dac_word, 32768);

      // Single sample: e=256 -> integ 256, word 32768+1+16
      enable           = 1'b1;
      dac_if.dac_ready = 1'b1;
      send(-256, 32785, 0);
      idle(6);
      chk("single_integ", dbinteg, 256);
      chk("single_drop", drop_cnt, 0);

      // Backpressure with a dropped strobe
      clear_loop();
      dac_if.dac_ready = 1'b0;
      send(-256, 32785, 0);
      idle(3);
      pulse(-256);
      idle(4);
      chk("bp_valid_held", dac_if.dac_valid, 1);
      chk("bp_word", dac_if.dac_word, 32785);
      chk("bp_drop", drop_cnt, 1);
      dac_if.dac_ready = 1'b1;
      idle(4);
      chk("bp_idle_valid", dac_if.dac_valid, 0);

      // Lock acquisition: e=-1 each time, integ -1..-16 -> word 32766
      clear_loop();
      for (int i = 0; i < 16; i++) begin
         if (i == 15)
            chk("lock_before_16th", locked, 0);
         send(1, 32766, 0);
         idle(6);
      end
      chk("lock_after_16th", locked, 1);
      send(5, 32766, 0);
      idle(6);
      chk("lock_lost", locked, 0);
      chk("lock_integ", dbinteg, -21);
      chk("lock_drop", drop_cnt, 1);

      // Most-negative input negates exactly and clamps the integrator
      clear_loop();
      send(32'sh8000_0000, 65535, 1);
      idle(6);
      chk("minneg_integ", dbinteg, 8388607);
      chk("minneg_locked", locked, 0);

      // Saturation: e=2^20 per sample, integ clamps on the 8th
      clear_loop();
      send(-(32'sd1 <<< 20), 65535, 1);
      idle(6);
      chk("sat_integ_1", dbinteg, 1048576);
      for (int i = 1; i < 9; i++) begin
         send(-(32'sd1 <<< 20), 65535, 1);
         idle(6);
      end
      chk("sat_integ_clamp", dbinteg, 8388607);
      hold = 1'b1;
      send(64, 65531, 0);
      idle(6);
      chk("hold_integ", dbinteg, 8388607);
      hold = 1'b0;

      // Reset while waiting in OUT
      dac_if.dac_ready = 1'b0;
      pulse(-256);
      idle(5);
      chk("pre_rst_valid", dac_if.dac_valid, 1);
      chk("pre_rst_word", dac_if.dac_word, 65535);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", dac_if.dac_valid, 0);
      chk("midrst_word", dac_if.dac_word, 32768);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      chk("post_rst_drop", drop_cnt, 0);
      chk("post_rst_integ", dbinteg, 0);
      dac_if.dac_ready = 1'b1;
      send(-256, 32785, 0);
      idle(6);

      for (int i = 0; i < 200 && sb.size() != 0; i++)
         @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
